fetch_queue: RTL

- Decoupling instruction queue between the fetch stage and decode in the 2-wide front end.
- Accepts up to two instructions per cycle from fetch, along with their PCs.
- Presents up to two oldest instructions per cycle to decode, in program order.
- Absorbs decode stalls without stalling the PC, and is flushed on branch misprediction.

---
 rtl/fetch_queue_pkg.sv | 27 ++
 rtl/fetch_queue_mem.sv | 31 +++
 rtl/fetch_queue.sv | 98 +++++++++
 3 files changed

// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared front-end constants and the fetch-queue entry type.
// The macro block below is the shared constants header for the front end:
// decode and fetch size themselves against FQ_DEPTH / FQ_PTR_LEN.
`ifndef INSN_LEN
`define INSN_LEN 32
`endif
`ifndef ADDR_LEN
`define ADDR_LEN 32
`endif
`ifndef FQ_DEPTH
`define FQ_DEPTH 8
`endif
`ifndef FQ_PTR_LEN
`define FQ_PTR_LEN 3
`endif

package fetch_queue_pkg;
  localparam int INSN_W   = `INSN_LEN;
  localparam int ADDR_W   = `ADDR_LEN;
  localparam int FQ_DEPTH = `FQ_DEPTH;
  localparam int FQ_PTR_W = `FQ_PTR_LEN;

  typedef struct packed {
    logic [INSN_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
  } fq_entry_t;
endpackage

// File: rtl/fetch_queue_mem.sv
// fetch_queue_mem: DEPTH-entry {inst, pc} register array, no reset.
// Ports: clk; two write ports (we*/waddr*/wdata*); two combinational
// read ports (raddr*/rdata*). The two write addresses are always distinct.
module fetch_queue_mem
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int PTR_W = FQ_PTR_W
) (
  input  logic             clk,
  input  logic             we0,
  input  logic [PTR_W-1:0] waddr0,
  input  fq_entry_t        wdata0,
  input  logic             we1,
  input  logic [PTR_W-1:0] waddr1,
  input  fq_entry_t        wdata1,
  input  logic [PTR_W-1:0] raddr0,
  output fq_entry_t        rdata0,
  input  logic [PTR_W-1:0] raddr1,
  output fq_entry_t        rdata1
);
  fq_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we0) mem_q[waddr0] <= wdata0;
    if (we1) mem_q[waddr1] <= wdata1;
  end

  assign rdata0 = mem_q[raddr0];
  assign rdata1 = mem_q[raddr1];
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: 2-in / 2-out decoupling queue between fetch and decode.
// Ports: clk, reset (sync high), flush (misprediction);
//   enq_*: instruction pair from fetch, enq_ready = >=2 free entries;
//   deq_*: two oldest entries to decode (zero-latency read), deq_stall;
//   count: occupied entries.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int PTR_W = FQ_PTR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              enq_valid,
  input  logic [INSN_W-1:0] enq_inst1,
  input  logic [INSN_W-1:0] enq_inst2,
  input  logic              enq_invalid2,
  input  logic [ADDR_W-1:0] enq_pc,
  output logic              enq_ready,
  input  logic              deq_stall,
  output logic              deq_valid1,
  output logic              deq_valid2,
  output logic [INSN_W-1:0] deq_inst1,
  output logic [INSN_W-1:0] deq_inst2,
  output logic [ADDR_W-1:0] deq_pc1,
  output logic [ADDR_W-1:0] deq_pc2,
  output logic [PTR_W:0]    count
);
  localparam logic [PTR_W:0] CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] CNT_TWO = (PTR_W+1)'(2);
  // Highest occupancy that still leaves room for a full pair.
  localparam logic [PTR_W:0] ENQ_MAX = (PTR_W+1)'(DEPTH - 2);

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [PTR_W:0]   n_enq, n_deq;
  logic             enq_fire, deq_fire;
  fq_entry_t        wdata0, wdata1, rdata0, rdata1;

  // Only registered count feeds enq_ready, so fetch sees no comb path
  // from its own valid or from decode's stall.
  assign enq_ready = (count_q <= ENQ_MAX);
  assign enq_fire  = enq_valid & enq_ready & ~flush;
  assign deq_fire  = ~deq_stall & ~flush;

  assign n_enq = enq_fire ? (enq_invalid2 ? CNT_ONE : CNT_TWO) : '0;
  assign n_deq = deq_fire ? ((count_q >= CNT_TWO) ? CNT_TWO : count_q) : '0;

  assign wdata0 = '{inst: enq_inst1, pc: enq_pc};
  assign wdata1 = '{inst: enq_inst2, pc: enq_pc + ADDR_W'(4)};

  fetch_queue_mem #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_mem (
    .clk    (clk),
    .we0    (enq_fire),
    .waddr0 (tail_q),
    .wdata0 (wdata0),
    .we1    (enq_fire & ~enq_invalid2),
    .waddr1 (tail_q + PTR_W'(1)),
    .wdata1 (wdata1),
    .raddr0 (head_q),
    .rdata0 (rdata0),
    .raddr1 (head_q + PTR_W'(1)),
    .rdata1 (rdata1)
  );

  always_comb begin
    head_d  = head_q + n_deq[PTR_W-1:0];
    tail_d  = tail_q + n_enq[PTR_W-1:0];
    count_d = count_q + n_enq - n_deq;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset, so outputs are masked by occupancy.
  assign deq_valid1 = (count_q >= CNT_ONE);
  assign deq_valid2 = (count_q >= CNT_TWO);
  assign deq_inst1  = deq_valid1 ? rdata0.inst : '0;
  assign deq_pc1    = deq_valid1 ? rdata0.pc   : '0;
  assign deq_inst2  = deq_valid2 ? rdata1.inst : '0;
  assign deq_pc2    = deq_valid2 ? rdata1.pc   : '0;
  assign count      = count_q;
endmodule
